// File: rtl/serial_addsub_nzcv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_pkg
//  Purpose  : Shared types and constants for the serial add/subtract unit:
//             opcode encoding, NZCV flag bit positions and FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  // Bit positions inside the 4-bit flags vector
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  // FSM encoding, kept as plain constants so older tools can reuse them
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage
`default_nettype wire

// File: rtl/serial_addsub_nzcv_chunk.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_chunk
//  Purpose  : Combinational W-bit ripple adder slice with carry in/out.
//  Ports    : a, b  [W-1:0] in  - operand slices
//             cin           in  - carry into bit 0
//             sum   [W-1:0] out - a + b + cin (low W bits)
//             cout          out - carry out of bit W-1
//  Revision : 1.0  initial release
// ============================================================================
module addsub_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/serial_addsub_nzcv.sv
`default_nettype none
// ============================================================================
//  Module   : serial_addsub_nzcv
//  Purpose  : Multi-cycle N-bit ADD/SUB/ADC/SBC unit producing NZCV flags.
//             Works CHUNK bits per cycle, LSB chunk first, with a registered
//             carry between chunks. valid/ready handshake on both sides.
//  Ports    : clk              in  - clock, all state on rising edge
//             rst_n            in  - synchronous active-low reset
//             in_valid         in  - request valid
//             in_ready         out - request can be accepted (IDLE only)
//             op     [1:0]     in  - 00 ADD, 01 SUB, 10 ADC, 11 SBC
//             a, b   [N-1:0]   in  - operands
//             cin              in  - carry in for ADC/SBC
//             out_valid        out - result/flags valid
//             out_ready        in  - consumer accepts result
//             result [N-1:0]   out - a op b modulo 2^N
//             flags  [3:0]     out - {N, Z, C, V}
//  Revision : 1.0  initial release
// ============================================================================
module serial_addsub_nzcv
  import addsub_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  localparam int STEPS = N / CHUNK;
  // cnt must reach STEPS: the cycle after the last chunk is the DONE transition
  localparam int CW    = (STEPS + 1 > 2) ? $clog2(STEPS + 1) : 1;

  generate
    if (N % CHUNK != 0) begin : g_bad_width
      $error("serial_addsub_nzcv: N must be a multiple of CHUNK");
    end
  endgenerate

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    a_sh;      // operand A, consumed from the bottom
  logic [N-1:0]    b_sh;      // operand B' (already inverted for SUB/SBC)
  logic [N-1:0]    res_sh;    // result, filled from the top downwards
  logic            carry;
  logic            zacc;      // all chunks so far were zero
  logic [3:0]      flags_r;

  logic [N-1:0]     b_eff;
  logic             c0;
  logic [CHUNK-1:0] sum;
  logic             cout;
  logic [N-1:0]     res_next;
  logic             z_next;
  logic [3:0]       flags_next;

  // Subtraction is A + ~B + 1 (SUB) or A + ~B + cin (SBC)
  always_comb begin
    b_eff = b;
    c0    = 1'b0;
    case (op_e'(op))
      OP_ADD: begin b_eff = b;  c0 = 1'b0; end
      OP_SUB: begin b_eff = ~b; c0 = 1'b1; end
      OP_ADC: begin b_eff = b;  c0 = cin;  end
      OP_SBC: begin b_eff = ~b; c0 = cin;  end
      default: begin b_eff = b; c0 = 1'b0; end
    endcase
  end

  addsub_chunk #(.W(CHUNK)) u_chunk (
    .a    (a_sh[CHUNK-1:0]),
    .b    (b_sh[CHUNK-1:0]),
    .cin  (carry),
    .sum  (sum),
    .cout (cout)
  );

  // New chunk enters at the top; after STEPS shifts chunk 0 sits at the bottom
  generate
    if (STEPS == 1) begin : g_res_single
      assign res_next = sum;
    end else begin : g_res_shift
      assign res_next = {sum, res_sh[N-1:CHUNK]};
    end
  endgenerate

  assign z_next = zacc & (sum == '0);

  // Valid only on the last chunk: a_sh/b_sh then hold the operand MSB chunk
  always_comb begin
    flags_next         = '0;
    flags_next[FLAG_N] = sum[CHUNK-1];
    flags_next[FLAG_Z] = z_next;
    flags_next[FLAG_C] = cout;
    flags_next[FLAG_V] = (a_sh[CHUNK-1] == b_sh[CHUNK-1]) &&
                         (sum[CHUNK-1] != a_sh[CHUNK-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      carry   <= 1'b0;
      zacc    <= 1'b0;
      flags_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b_eff;
            carry <= c0;
            zacc  <= 1'b1;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt == CW'(STEPS)) begin
            state <= S_DONE;
          end else begin
            a_sh   <= a_sh >> CHUNK;
            b_sh   <= b_sh >> CHUNK;
            res_sh <= res_next;
            carry  <= cout;
            zacc   <= z_next;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(STEPS - 1)) begin
              flags_r <= flags_next;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n && (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign result    = res_sh;
  assign flags     = flags_r;

endmodule
`default_nettype wire
